// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers for the frame FIFO: pointer address width and packed beat entry width.
package axis_fifo_pkg;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Entry layout is {user?, keep?, last, data}; disabled fields take no storage.
  function automatic int entry_width(input int data_w, input int keep_en, input int keep_w,
                                     input int user_en, input int user_w);
    return data_w + ((keep_en != 0) ? keep_w : 0) + 1 + ((user_en != 0) ? user_w : 0);
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat store: one write port, one registered read port (the FIFO output register).
// Read data appears the cycle after re; no reset on storage or read data so it maps to block RAM.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [addr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         re,
  input  logic [addr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_frame_fifo.sv
// Frame-mode AXIS FIFO: a frame is released one cycle after its tlast commits; oversize frames are
// dropped, never stalled. Optional bad-frame drop on tuser[0] via AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN.
module axis_frame_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int AW       = addr_width(DEPTH);
  localparam int EW       = entry_width(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH, USER_ENABLE, USER_WIDTH);
  localparam int LAST_OFS = DATA_WIDTH;
  localparam int KEEP_OFS = DATA_WIDTH + 1;
  localparam int USER_OFS = KEEP_OFS + ((KEEP_ENABLE != 0) ? KEEP_WIDTH : 0);

  logic [AW:0]   wr_ptr_cur, wr_ptr_commit, rd_ptr;
  logic          drop_frame;
  logic          empty, full_cur, full_wr;
  logic          wr_acc, mem_we, rd_en, bad_last;
  logic [EW-1:0] wr_entry, rd_entry;

  assign empty    = (wr_ptr_commit == rd_ptr);
  assign full_cur = (wr_ptr_cur == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign full_wr  = (wr_ptr_cur == {~wr_ptr_commit[AW], wr_ptr_commit[AW-1:0]});

  // Accepting while full_wr or dropping keeps the upstream mux moving; those beats are discarded.
  assign s_axis_tready = !full_cur || full_wr || drop_frame;
  assign wr_acc        = s_axis_tvalid && s_axis_tready;
  assign mem_we        = wr_acc && !drop_frame && !full_wr;
  assign rd_en         = !empty && (!m_axis_tvalid || m_axis_tready);

`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
  if (USER_ENABLE == 0) begin : g_bad_needs_user
    $error("AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN requires USER_ENABLE=1");
  end
  assign bad_last = s_axis_tuser[0];
`else
  assign bad_last = 1'b0;
`endif

  assign wr_entry[DATA_WIDTH-1:0] = s_axis_tdata;
  assign wr_entry[LAST_OFS]       = s_axis_tlast;
  assign m_axis_tdata             = rd_entry[DATA_WIDTH-1:0];
  assign m_axis_tlast             = rd_entry[LAST_OFS];

  if (KEEP_ENABLE != 0) begin : g_keep
    assign wr_entry[KEEP_OFS +: KEEP_WIDTH] = s_axis_tkeep;
    assign m_axis_tkeep = rd_entry[KEEP_OFS +: KEEP_WIDTH];
  end else begin : g_no_keep
    assign m_axis_tkeep = '1;
  end

  if (USER_ENABLE != 0) begin : g_user
    assign wr_entry[USER_OFS +: USER_WIDTH] = s_axis_tuser;
    assign m_axis_tuser = rd_entry[USER_OFS +: USER_WIDTH];
  end else begin : g_no_user
    assign m_axis_tuser = '0;
  end

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_cur[AW-1:0]),
    .wdata (wr_entry),
    .re    (rd_en),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      rd_ptr            <= '0;
      drop_frame        <= 1'b0;
      m_axis_tvalid     <= 1'b0;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;

      if (wr_acc) begin
        if (drop_frame) begin
          if (s_axis_tlast) drop_frame <= 1'b0;
        end else if (full_wr) begin
          // Open frame already fills the whole buffer: rewind it and swallow the remainder.
          wr_ptr_cur      <= wr_ptr_commit;
          drop_frame      <= !s_axis_tlast;
          status_overflow <= 1'b1;
        end else begin
          wr_ptr_cur <= wr_ptr_cur + 1'b1;
          if (s_axis_tlast) begin
            if (bad_last) begin
              wr_ptr_cur       <= wr_ptr_commit;
              status_bad_frame <= 1'b1;
            end else begin
              wr_ptr_commit     <= wr_ptr_cur + 1'b1;
              status_good_frame <= 1'b1;
            end
          end
        end
      end

      if (rd_en) begin
        rd_ptr        <= rd_ptr + 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed-plus-random bench for axis_frame_fifo (DEPTH=16) against a frame-level reference model.
module tb_axis_frame_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int UW    = 1;
`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
  localparam bit BAD_DROP = 1'b1;
`else
  localparam bit BAD_DROP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          status_overflow, status_bad_frame, status_good_frame;

  beat_t exp_q[$];
  beat_t frm[$];
  int    checks = 0, failures = 0;
  int    good_cnt = 0, ovf_cnt = 0, bad_cnt = 0;
  int    exp_good = 0, exp_ovf = 0, exp_bad = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready
  int    last_stalls = 0;

  always #5 clk = ~clk;

  axis_frame_fifo #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (DW),
    .KEEP_ENABLE (1),
    .KEEP_WIDTH  (KW),
    .USER_ENABLE (1),
    .USER_WIDTH  (UW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .status_overflow   (status_overflow),
    .status_bad_frame  (status_bad_frame),
    .status_good_frame (status_good_frame)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: picks tready for the coming edge, then scores any handshake against the model.
  initial begin
    beat_t e;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_axis_tready = (rdy_mode == 0) ? 1'b1 :
                      (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (rst === 1'b0) begin
        if (status_good_frame) good_cnt++;
        if (status_overflow)   ovf_cnt++;
        if (status_bad_frame)  bad_cnt++;
        if (m_axis_tvalid) begin
          chk("beat_is_committed", 64'(exp_q.size() != 0), 64'd1);
          if (m_axis_tready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'(e));
          end
        end
      end
    end
  end

  task automatic make_frame(input int len, input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input bit rnd, input bit bad);
    beat_t b;
    frm.delete();
    for (int i = 0; i < len; i++) begin
      b.d = rnd ? DW'($urandom) : base + DW'(i) * step;
      b.k = rnd ? KW'($urandom) : {KW{1'b1}};
      b.l = (i == len - 1);
      b.u = (i == len - 1) ? UW'(bad) : UW'($urandom);
      frm.push_back(b);
    end
  endtask

  task automatic send_beat(input beat_t b, output int waits);
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b.d;
    s_axis_tkeep  = b.k;
    s_axis_tlast  = b.l;
    s_axis_tuser  = b.u;
    waits = 0;
    while (!s_axis_tready && waits < 3000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 3000) chk("tready_timeout", 64'(waits), 64'd0);
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  // Frame-level model: >DEPTH beats is an overflow drop, a flagged bad frame is dropped when the
  // feature is built in, anything else is delivered verbatim after its last beat is accepted.
  task automatic send_frame();
    int w;
    last_stalls = 0;
    for (int i = 0; i < frm.size(); i++) begin
      send_beat(frm[i], w);
      last_stalls += w;
    end
    if (frm.size() > DEPTH) exp_ovf++;
    else if (BAD_DROP && frm[frm.size()-1].u[0]) exp_bad++;
    else begin
      foreach (frm[i]) exp_q.push_back(frm[i]);
      exp_good++;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_idle_valid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_good_cnt"}, 64'(good_cnt), 64'(exp_good));
    chk({tag, "_ovf_cnt"}, 64'(ovf_cnt), 64'(exp_ovf));
    chk({tag, "_bad_cnt"}, 64'(bad_cnt), 64'(exp_bad));
  endtask

  initial begin
    int w;
    rst = 1'b1;
    #2;
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_status", 64'({status_overflow, status_bad_frame, status_good_frame}), 64'd0);
    chk("reset_tready", 64'(s_axis_tready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single frame: first beat visible one edge after the tlast edge.
    rdy_mode = 0;
    make_frame(3, 32'h11, 32'h11, 1'b0, 1'b0);
    send_frame();
    chk("t1_valid_at_tlast_edge", 64'(m_axis_tvalid), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_valid_next_edge", 64'(m_axis_tvalid), 64'd1);
    chk("t1_first_data", 64'(m_axis_tdata), 64'h11);
    drain("t1");

    // Back-pressure: frames of 1..10 random beats with a 50% ready sink.
    rdy_mode = 1;
    for (int f = 1; f <= 10; f++) begin
      make_frame(f, '0, '0, 1'b1, 1'b0);
      send_frame();
    end
    drain("t2");

    // Oversize: 20-beat frame is dropped without stalling the source, then a small frame passes.
    rdy_mode = 0;
    make_frame(20, 32'h100, 32'h1, 1'b0, 1'b0);
    send_frame();
    chk("t3_no_stall_oversize", 64'(last_stalls), 64'd0);
    make_frame(2, 32'hA0, 32'h1, 1'b0, 1'b0);
    send_frame();
    chk("t3_no_stall_small", 64'(last_stalls), 64'd0);
    drain("t3");

    // Wrap-around: 200 beats through a 16-entry buffer with a continuous drain.
    for (int f = 0; f < 40; f++) begin
      make_frame(5, '0, '0, 1'b1, 1'b0);
      send_frame();
    end
    drain("t4");

    // Reset mid-frame while a committed frame is held at the output.
    rdy_mode = 2;
    make_frame(1, 32'h99, 32'h0, 1'b0, 1'b0);
    send_frame();
    repeat (3) @(negedge clk);
    chk("t5_held_valid", 64'(m_axis_tvalid), 64'd1);
    make_frame(4, 32'hC0, 32'h1, 1'b0, 1'b0);
    send_beat(frm[0], w);
    send_beat(frm[1], w);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_valid_async_clear", 64'(m_axis_tvalid), 64'd0);
    chk("t5_status_clear", 64'({status_overflow, status_bad_frame, status_good_frame}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    chk("t5_tready_after_reset", 64'(s_axis_tready), 64'd1);
    make_frame(1, 32'h55, 32'h0, 1'b0, 1'b0);
    send_frame();
    drain("t5");

    // Bad-flagged frame followed by a good one; dropped only when the feature is built in.
    rdy_mode = 1;
    make_frame(4, 32'hB0, 32'h1, 1'b0, 1'b1);
    send_frame();
    make_frame(1, 32'h77, 32'h0, 1'b0, 1'b0);
    send_frame();
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_frame_fifo.md
Name: axis_frame_fifo

Overview:
- Frame-mode AXI4-Stream FIFO that sits directly downstream of the 2-port stream mux.
- Buffers beats and releases a frame to the master side only after its tlast beat has been accepted and committed.
- Frames that cannot fit in the buffer are dropped, so the mux is never back-pressured indefinitely.
- Provides per-frame status pulses for the control/monitor logic.

Parameters:
- DEPTH, 4096: buffer depth in beats; power of two, >= 4.
- DATA_WIDTH, 32: tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8): store and propagate tkeep.
- KEEP_WIDTH, (DATA_WIDTH/8): tkeep width.
- USER_ENABLE, 1: store and propagate tuser.
- USER_WIDTH, 1: tuser width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tuser  in  USER_WIDTH  input sideband.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables; all ones when KEEP_ENABLE=0.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tuser  out  USER_WIDTH  output sideband; zero when USER_ENABLE=0.
- status_overflow  out  1  one-cycle pulse: frame dropped as oversize.
- status_bad_frame  out  1  one-cycle pulse: frame dropped as bad (feature only; else tied 0).
- status_good_frame  out  1  one-cycle pulse: frame committed.

Behaviour:
- Storage and pointers:
  - Memory entries hold {tdata, tkeep, tlast, tuser}.
  - Pointers are ADDR_WIDTH+1 bits, ADDR_WIDTH = $clog2(DEPTH).
  - wr_ptr_cur: next write location. wr_ptr_commit: end of the last committed frame. rd_ptr: next read location.
  - empty = (wr_ptr_commit == rd_ptr).
  - full_cur = (wr_ptr_cur == rd_ptr with MSB inverted).
  - full_wr = (wr_ptr_cur == wr_ptr_commit with MSB inverted), i.e. one open frame occupies all DEPTH entries.
- Input side:
  - s_axis_tready = !full_cur || full_wr || drop_frame.
  - Beat accepted (tvalid && tready), not dropping, not full_wr: write memory at wr_ptr_cur; wr_ptr_cur++.
  - Accepted beat with tlast (not dropping): wr_ptr_commit <= wr_ptr_cur+1; pulse status_good_frame.
- Oversize frames:
  - Beat accepted while full_wr: wr_ptr_cur <= wr_ptr_commit; set drop_frame; pulse status_overflow once.
  - If that beat has tlast, drop_frame is not set.
  - While drop_frame: beats are accepted and discarded; drop_frame clears on the accepted tlast beat.
- Output side:
  - Single output register stage.
  - If !empty && (!m_axis_tvalid || m_axis_tready): load the register from memory[rd_ptr], rd_ptr++, m_axis_tvalid <= 1.
  - Else if m_axis_tready: m_axis_tvalid <= 0.
- Latency: tlast accepted on edge E into an empty FIFO gives m_axis_tvalid high after edge E+1, showing the first beat of the frame.
- No beat of a frame is ever presented before that frame is committed.
- Simultaneous read and write on the same cycle are both legal; the read only ever sees committed entries.
- Reset (async, any time including mid-frame): all pointers 0, drop_frame 0, m_axis_tvalid 0, all status outputs 0. Output data registers are don't-care.
- After reset, s_axis_tready is 1. A partially received frame at reset is lost; the source is expected to restart at frame start.
- Wrap-around: pointers wrap modulo 2*DEPTH. Full/empty are distinguished by the MSB.

Optional Feature:
- Macro: AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN.
- Defined:
  - Accepted tlast beat with s_axis_tuser[0]=1 (not dropping) rewinds: wr_ptr_cur <= wr_ptr_commit, no commit.
  - Pulses status_bad_frame instead of status_good_frame.
  - Requires USER_ENABLE=1; elaboration error otherwise.
- Undefined: tuser is stored and forwarded unchanged; status_bad_frame tied 0.

Decomposition:
- Package axis_fifo_pkg: ADDR_WIDTH calculation function, beat entry width function.
- Sub-module axis_fifo_ram: simple dual-port RAM, one write port and one synchronous read port, DEPTH x entry width, inferable as block RAM.
- FIFO control, pointers and the output register stay in the top module.

Test Plan:
- Single frame: 3-beat frame, DEPTH=16, tdata 0x11/0x22/0x33, m_axis_tready=1.
  -> no m_axis_tvalid until one cycle after the tlast accept.
  -> output 0x11, 0x22, 0x33, with tlast on 0x33.
  -> one status_good_frame pulse.
- Back-pressure: 10 frames of 1..10 beats, random m_axis_tready at 50%.
  -> output identical and in order.
  -> tready never drops except when full_cur with committed frames.
- Oversize: DEPTH=16, 20-beat frame, then a 2-beat frame 0xA0/0xA1.
  -> status_overflow pulses once.
  -> tready stays 1 throughout.
  -> only 0xA0, 0xA1 appear on the output.
- Wrap-around: DEPTH=16, 40 frames of 5 beats with continuous drain.
  -> all 200 beats correct, no overflow pulses.
- Reset mid-frame: assert rst after 2 beats of a 4-beat frame.
  -> m_axis_tvalid immediately 0.
  -> after release, a new 1-beat frame 0x55 is output alone.
- Feature on: 4-beat frame with tuser=1 on tlast, then a good 1-beat frame 0x77.
  -> status_bad_frame pulses.
  -> only 0x77 is output.
